mmio_uart_tx: RTL
=================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter; the responder on the single-cycle MIPS data bus (memwrite/memaddr/memwritedata/memreaddata).
//  CPU stores bytes into an 8-entry FIFO. An 8N1 serial engine drains the FIFO onto txd at a programmable baud rate.
//  The top level ORs memreaddata into the CPU read path when sel=1.
// PARAMETERS
//  BASE_ADDR   32'hFFFF_0000  16-byte aligned base of the 4-word register window
//  DEF_DIV     16'd27         BAUDDIV reset value; tick16 = clk/BAUDDIV (27 -> ~115200 baud at 50 MHz)
//  FIFO_AW     3              FIFO address width; depth = 2**FIFO_AW
// PORTS
//  clk           in   1   system clock, all state on rising edge
//  reset         in   1   asynchronous, active-high reset
//  memwrite      in   1   CPU store strobe, single cycle
//  memaddr       in   32  CPU data address
//  memwritedata  in   32  CPU store data
//  memreaddata   out  32  register read data; combinational from memaddr; 0 when sel=0
//  sel           out  1   memaddr[31:4]==BASE_ADDR[31:4]
//  txd           out  1   serial output
//  tx_busy       out  1   1 while FSM is not IDLE
//  irq           out  1   level: CTRL.irq_en & fifo_empty & ~tx_busy
// BEHAVIOUR
//  Register map (offset memaddr[3:2]):
//   0x0 TXDATA  W: push memwritedata[7:0]; R: 0
//   0x4 STATUS  R: [0]full [1]empty [2]tx_busy [3]overflow [7:4]count, rest 0; W (any value): clear overflow
//   0x8 BAUDDIV RW [15:0]; value 0 is treated as 1
//   0xC CTRL    RW [0]tx_en [1]irq_en
//  Reset values: FIFO empty, overflow=0, BAUDDIV=DEF_DIV, CTRL=2'b01, FSM=IDLE, divider/bit counters=0,
//   txd=1 (0 with IRDA_EN), tx_busy=0, irq=0. Reset mid-frame aborts the frame immediately.
//  Write semantics:
//   Writes take effect at the clk edge where memwrite & sel.
//   Push to a full FIFO is dropped and sets overflow (sticky), unless a pop happens the same cycle; then push is accepted and count is unchanged.
//  Baud divider:
//   Runs only when FSM != IDLE; cleared to 0 on leaving IDLE.
//   tick16 pulses one clk when div_cnt == BAUDDIV-1, then div_cnt wraps to 0.
//   A BAUDDIV write mid-frame applies from the next wrap.
//   Each serial bit = 16 tick16; one frame = 160 tick16.
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE
//   IDLE: if tx_en & ~empty: pop head into shift reg the same cycle, go START.
//   START: txd=0 for 16 ticks.
//   DATA: 8 bits, LSB first, 16 ticks each; bit index 0..7.
//   STOP: txd=1 for 16 ticks, then IDLE.
//   Back-to-back frames: exactly 1 clk in IDLE between stop end and next start.
//  Clearing tx_en mid-frame completes the current frame; no further pops.
//  FIFO: circular, FIFO_AW-bit pointers wrap naturally; count is FIFO_AW+1 bits, 0..2**FIFO_AW.
// CONFIGURATION
//  IRDA_EN defined: txd is IrDA SIR encoded; idle level 0.
//   Each 0 bit (start and data zeros) drives txd=1 during ticks 0-2 of its 16-tick bit, else 0.
//   1 bits and stop drive 0.
//  IRDA_EN undefined: plain NRZ 8N1, idle 1. Register map and timing are identical in both modes.
// TESTING
//  1. BAUDDIV=1, write 0x55 to TXDATA -> txd low 16 clk; bits 1,0,1,0,1,0,1,0 at 16 clk each; high 16 clk; tx_busy high 160 clk.
//  2. tx_en=0, 9 writes 0x01..0x09 -> 9th dropped; STATUS=0x89 (count 8, overflow, full); write STATUS -> STATUS=0x81.
//  3. Queue 0xA5,0x3C with BAUDDIV=1 -> two frames separated by exactly 1 idle clk; then empty & irq=1 (irq_en=1).
//  4. Assert reset at clk 40 of a frame -> txd=1, tx_busy=0, STATUS=0x02, BAUDDIV=27 asynchronously.
//  5. BAUDDIV=0 vs 1 -> identical txd waveform; read 0x8 returns 0 and 1 respectively.
//  6. IRDA_EN, BAUDDIV=1, write 0x00 -> nine 3-clk high pulses at 16-clk spacing, then txd=0.

Source files
------------

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: single-cycle CPU data-bus slice seen by the UART.
// master = CPU side, slave = UART register window.
interface mmio_uart_tx_if;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic        sel;

    modport master (
        output memwrite,
        output memaddr,
        output memwritedata,
        input  memreaddata,
        input  sel
    );

    modport slave (
        input  memwrite,
        input  memaddr,
        input  memwritedata,
        output memreaddata,
        output sel
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO UART transmitter, 8-entry FIFO feeding an 8N1 engine.
// Define IRDA_EN for IrDA SIR encoded txd (idle level 0).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter logic [15:0] DEF_DIV   = 16'd27,
    parameter int          FIFO_AW   = 3
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          txd,
    output logic          tx_busy,
    output logic          irq
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0]      CNT_ONE = 1;

`ifdef IRDA_EN
    localparam bit IRDA = 1'b1;
`else
    localparam bit IRDA = 1'b0;
`endif
    localparam logic IDLE_LVL = ~IRDA;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t state;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CW-1:0]      count;
    logic               overflow;

    logic [15:0] bauddiv;
    logic [15:0] eff_div;
    logic [15:0] cur_div;
    logic [15:0] div_cnt;
    logic [1:0]  ctrl;

    logic [7:0] shift;
    logic [3:0] tick_cnt;
    logic [2:0] bit_idx;

    logic [1:0]  off;
    logic        wr;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        tick16;
    logic [31:0] rdata;
    logic        unused_bits;

    assign bus.sel = (bus.memaddr[31:4] == BASE_ADDR[31:4]);
    assign off     = bus.memaddr[3:2];
    assign wr      = bus.memwrite & bus.sel;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop      = (state == S_IDLE) & ctrl[0] & ~empty;
    assign push_req = wr & (off == 2'd0);
    assign push     = push_req & (~full | pop);

    assign eff_div = (bauddiv == 16'd0) ? 16'd1 : bauddiv;
    assign tick16  = (state != S_IDLE) & (div_cnt == cur_div - 16'd1);

    assign tx_busy = (state != S_IDLE);
    assign irq     = ctrl[1] & empty & ~tx_busy;

    assign unused_bits = ^{bus.memaddr[1:0], bus.memwritedata[31:16]};

    // Line level for a bit value; `early` marks ticks 0-2 of the bit.
    function automatic logic enc(input logic v, input logic early);
        return IRDA ? (~v & early) : v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push & ~pop)
                count <= count + CNT_ONE;
            else if (pop & ~push)
                count <= count - CNT_ONE;
            if (push_req & full & ~pop)
                overflow <= 1'b1;
            else if (wr & (off == 2'd1))
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.memwritedata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bauddiv <= DEF_DIV;
            ctrl    <= 2'b01;
        end else if (wr) begin
            if (off == 2'd2)
                bauddiv <= bus.memwritedata[15:0];
            if (off == 2'd3)
                ctrl <= bus.memwritedata[1:0];
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            2'd1:    rdata[7:0]  = {4'(count), overflow, tx_busy, empty, full};
            2'd2:    rdata[15:0] = bauddiv;
            2'd3:    rdata[1:0]  = ctrl;
            default: rdata       = '0;
        endcase
    end

    assign bus.memreaddata = bus.sel ? rdata : '0;

    // The divisor is latched at each wrap so a mid-frame write never
    // strands div_cnt above a freshly lowered terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            cur_div <= 16'd1;
        end else if (state == S_IDLE) begin
            div_cnt <= '0;
            cur_div <= eff_div;
        end else if (tick16) begin
            div_cnt <= '0;
            cur_div <= eff_div;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= IDLE_LVL;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= S_START;
                        txd      <= enc(1'b0, 1'b1);
                    end
                end
                S_START: begin
                    if (tick16) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            state <= S_DATA;
                            txd   <= enc(shift[0], 1'b1);
                        end else begin
                            txd <= enc(1'b0, tick_cnt < 4'd2);
                        end
                    end
                end
                S_DATA: begin
                    if (tick16) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= S_STOP;
                                txd   <= enc(1'b1, 1'b1);
                            end else begin
                                shift <= {1'b0, shift[7:1]};
                                txd   <= enc(shift[1], 1'b1);
                            end
                        end else begin
                            txd <= enc(shift[0], tick_cnt < 4'd2);
                        end
                    end
                end
                S_STOP: begin
                    if (tick16) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            state <= S_IDLE;
                            txd   <= IDLE_LVL;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
